// File: rtl/alu_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals for alu_arbiter.
// Names are from the arbiter's point of view; the environment drives the *_i side.
interface alu_arbiter_if;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [31:0] req0_src_a_i;
  logic [31:0] req0_src_b_i;
  logic [3:0]  req0_op_i;
  logic [31:0] req1_src_a_i;
  logic [31:0] req1_src_b_i;
  logic [3:0]  req1_op_i;
  logic [31:0] alu_src_a_o;
  logic [31:0] alu_src_b_o;
  logic [3:0]  alu_op_o;
  logic [31:0] alu_result_i;
  logic        zero_flag_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic        rsp_id_o;
  logic [31:0] rsp_result_o;
  logic        rsp_zero_o;
  logic        rsp_err_o;

  modport slave (
    input  req_valid_i, req0_src_a_i, req0_src_b_i, req0_op_i,
    input  req1_src_a_i, req1_src_b_i, req1_op_i,
    input  alu_result_i, zero_flag_i, rsp_ready_i,
    output req_ready_o, alu_src_a_o, alu_src_b_o, alu_op_o,
    output rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req0_src_a_i, req0_src_b_i, req0_op_i,
    output req1_src_a_i, req1_src_b_i, req1_op_i,
    output alu_result_i, zero_flag_i, rsp_ready_i,
    input  req_ready_o, alu_src_a_o, alu_src_b_o, alu_op_o,
    input  rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, rsp_err_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU, with a
// one-entry registered response slot that sustains one operation per cycle.
//
// state   | meaning
// S_EMPTY | response slot free, rsp_valid_o=0
// S_FULL  | response slot holds a result, rsp_valid_o=1
module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  alu_arbiter_if.slave bus
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  state_e      state_q;
  logic        ptr_q;
  logic        id_q;
  logic [31:0] result_q;
  logic        zero_q;
  logic        err_q;

  logic        win_vld;
  logic        win_id;
  logic [31:0] win_a;
  logic [31:0] win_b;
  logic [3:0]  win_op;
  logic        can_accept;
  logic        grant;
  logic        op_illegal;

  always_comb begin
    win_vld = 1'b0;
    win_id  = 1'b0;
    case (bus.req_valid_i)
      2'b01: begin
        win_vld = 1'b1;
        win_id  = 1'b0;
      end
      2'b10: begin
        win_vld = 1'b1;
        win_id  = 1'b1;
      end
      2'b11: begin
        win_vld = 1'b1;
        win_id  = RR_EN ? ptr_q : 1'b0;
      end
      default: begin
        win_vld = 1'b0;
        win_id  = 1'b0;
      end
    endcase
    // Reset must hold req_ready_o low even without a clock edge.
    if (!rst_ni) begin
      win_vld = 1'b0;
    end
  end

  assign win_a  = win_id ? bus.req1_src_a_i : bus.req0_src_a_i;
  assign win_b  = win_id ? bus.req1_src_b_i : bus.req0_src_b_i;
  assign win_op = win_id ? bus.req1_op_i    : bus.req0_op_i;

  assign bus.alu_src_a_o = win_vld ? win_a  : 32'd0;
  assign bus.alu_src_b_o = win_vld ? win_b  : 32'd0;
  assign bus.alu_op_o    = win_vld ? win_op : 4'b0000;

  assign can_accept      = (state_q == S_EMPTY) || bus.rsp_ready_i;
  assign grant           = win_vld && can_accept;
  assign bus.req_ready_o = grant ? (win_id ? 2'b10 : 2'b01) : 2'b00;
  assign op_illegal      = (win_op > 4'd9);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_EMPTY;
      ptr_q    <= 1'b0;
      id_q     <= 1'b0;
      result_q <= 32'd0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (grant) begin
            state_q <= S_FULL;
          end
        end
        S_FULL: begin
          // A drain with a simultaneous transfer keeps the slot full.
          if (bus.rsp_ready_i && !grant) begin
            state_q <= S_EMPTY;
          end
        end
        default: state_q <= S_EMPTY;
      endcase

      if (grant) begin
        id_q     <= win_id;
        err_q    <= op_illegal;
        result_q <= op_illegal ? 32'd0 : bus.alu_result_i;
        zero_q   <= op_illegal ? 1'b0  : bus.zero_flag_i;
        if (RR_EN) begin
          ptr_q <= ~win_id;
        end
      end
    end
  end

  assign bus.rsp_valid_o  = (state_q == S_FULL);
  assign bus.rsp_id_o     = id_q;
  assign bus.rsp_result_o = result_q;
  assign bus.rsp_zero_o   = zero_q;
  assign bus.rsp_err_o    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share stimulus;
// expected responses are queued on each expected grant and checked on output.
module tb_alu_arbiter;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } rsp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  valid;
  logic [31:0] a0, b0, a1, b1;
  logic [3:0]  op0, op1;
  logic        rdy;

  int n_cmp;
  int n_err;

  rsp_t q_a[$];
  rsp_t q_b[$];

  alu_arbiter_if ifa ();
  alu_arbiter_if ifb ();

  alu_arbiter #(.RR_EN(1'b1)) dut_rr (.clk_i(clk), .rst_ni(rst_n), .bus(ifa));
  alu_arbiter #(.RR_EN(1'b0)) dut_fp (.clk_i(clk), .rst_ni(rst_n), .bus(ifb));

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return $unsigned($signed(a) >>> b[4:0]);
      4'd8:    return {31'd0, $signed(a) < $signed(b)};
      4'd9:    return {31'd0, a < b};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Shared ALU model; flags zero on illegal ops so the arbiter's masking is visible.
  assign ifa.alu_result_i = alu_f(ifa.alu_src_a_o, ifa.alu_src_b_o, ifa.alu_op_o);
  assign ifa.zero_flag_i  = (ifa.alu_op_o > 4'd9) ? 1'b1 : (ifa.alu_result_i == 32'd0);
  assign ifb.alu_result_i = alu_f(ifb.alu_src_a_o, ifb.alu_src_b_o, ifb.alu_op_o);
  assign ifb.zero_flag_i  = (ifb.alu_op_o > 4'd9) ? 1'b1 : (ifb.alu_result_i == 32'd0);

  assign ifa.req_valid_i  = valid;
  assign ifa.req0_src_a_i = a0;
  assign ifa.req0_src_b_i = b0;
  assign ifa.req0_op_i    = op0;
  assign ifa.req1_src_a_i = a1;
  assign ifa.req1_src_b_i = b1;
  assign ifa.req1_op_i    = op1;
  assign ifa.rsp_ready_i  = rdy;
  assign ifb.req_valid_i  = valid;
  assign ifb.req0_src_a_i = a0;
  assign ifb.req0_src_b_i = b0;
  assign ifb.req0_op_i    = op0;
  assign ifb.req1_src_a_i = a1;
  assign ifb.req1_src_b_i = b1;
  assign ifb.req1_op_i    = op1;
  assign ifb.rsp_ready_i  = rdy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t exp_rsp(input logic id);
    logic [31:0] a, b;
    logic [3:0]  op;
    rsp_t        r;
    a      = id ? a1  : a0;
    b      = id ? b1  : b0;
    op     = id ? op1 : op0;
    r.id   = id;
    r.err  = (op > 4'd9);
    r.res  = r.err ? 32'd0 : alu_f(a, b, op);
    r.zero = r.err ? 1'b0  : (r.res == 32'd0);
    return r;
  endfunction

  task automatic chk_rsp(input string t, input logic v, input logic id, input logic [31:0] res,
                         input logic zero, input logic err, input logic has, input rsp_t e);
    chk({t, ".rsp_valid"}, v, has);
    if (has) begin
      chk({t, ".rsp_id"}, id, e.id);
      chk({t, ".rsp_result"}, res, e.res);
      chk({t, ".rsp_zero"}, zero, e.zero);
      chk({t, ".rsp_err"}, err, e.err);
    end
  endtask

  task automatic chk_alu(input string t, input logic [1:0] g, input logic [31:0] sa,
                         input logic [31:0] sb, input logic [3:0] op);
    if (g != 2'b00) begin
      chk({t, ".alu_src_a"}, sa, g[1] ? a1 : a0);
      chk({t, ".alu_src_b"}, sb, g[1] ? b1 : b0);
      chk({t, ".alu_op"}, op, g[1] ? op1 : op0);
    end else if (valid == 2'b00) begin
      chk({t, ".alu_idle"}, {sa ^ sb, 28'd0, op}, 64'd0);
    end
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick(input logic [1:0] ga, input logic [1:0] gb);
    rsp_t ea, eb;
    #1;
    ea = '0;
    eb = '0;
    if (q_a.size() > 0) ea = q_a[0];
    if (q_b.size() > 0) eb = q_b[0];
    chk("rr.req_ready", ifa.req_ready_o, ga);
    chk("fp.req_ready", ifb.req_ready_o, gb);
    chk_alu("rr", ga, ifa.alu_src_a_o, ifa.alu_src_b_o, ifa.alu_op_o);
    chk_alu("fp", gb, ifb.alu_src_a_o, ifb.alu_src_b_o, ifb.alu_op_o);
    chk_rsp("rr", ifa.rsp_valid_o, ifa.rsp_id_o, ifa.rsp_result_o, ifa.rsp_zero_o,
            ifa.rsp_err_o, q_a.size() > 0, ea);
    chk_rsp("fp", ifb.rsp_valid_o, ifb.rsp_id_o, ifb.rsp_result_o, ifb.rsp_zero_o,
            ifb.rsp_err_o, q_b.size() > 0, eb);
    if (rdy && q_a.size() > 0) void'(q_a.pop_front());
    if (rdy && q_b.size() > 0) void'(q_b.pop_front());
    if (ga != 2'b00) q_a.push_back(exp_rsp(ga[1]));
    if (gb != 2'b00) q_b.push_back(exp_rsp(gb[1]));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs();
    chk("rst.rr.req_ready", ifa.req_ready_o, 2'b00);
    chk("rst.fp.req_ready", ifb.req_ready_o, 2'b00);
    chk("rst.rr.rsp", {ifa.rsp_valid_o, ifa.rsp_id_o, ifa.rsp_zero_o, ifa.rsp_err_o}, 4'b0000);
    chk("rst.fp.rsp", {ifb.rsp_valid_o, ifb.rsp_id_o, ifb.rsp_zero_o, ifb.rsp_err_o}, 4'b0000);
    chk("rst.rr.rsp_result", ifa.rsp_result_o, 32'd0);
    chk("rst.fp.rsp_result", ifb.rsp_result_o, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    valid = 2'b11;
    rdy   = 1'b1;
    a0 = 32'd1; b0 = 32'd2; op0 = 4'd0;
    a1 = 32'd3; b1 = 32'd4; op1 = 4'd0;
    #3;
    chk_reset_outputs();

    // Single ADD from requester 0
    @(negedge clk);
    rst_n = 1'b1;
    valid = 2'b01;
    a0 = 32'd10; b0 = 32'd20; op0 = 4'd0;
    tick(2'b01, 2'b01);
    valid = 2'b00;
    tick(2'b00, 2'b00);

    // Illegal op from requester 1
    valid = 2'b10;
    a1 = 32'h1234_0000; b1 = 32'h0000_5678; op1 = 4'b1100;
    tick(2'b10, 2'b10);

    // Both continuously valid, consumer always ready
    valid = 2'b11;
    a0 = 32'd100;  b0 = 32'd100;  op0 = 4'd1;
    a1 = 32'h0AA;  b1 = 32'h055;  op1 = 4'd2;
    tick(2'b01, 2'b01);
    tick(2'b10, 2'b01);
    tick(2'b01, 2'b01);
    tick(2'b10, 2'b01);

    // Back-pressure for three cycles, then drain and accept together
    rdy = 1'b0;
    tick(2'b00, 2'b00);
    tick(2'b00, 2'b00);
    tick(2'b00, 2'b00);
    rdy = 1'b1;
    tick(2'b01, 2'b01);

    // Hold a response with ptr pointing at requester 1, then reset asynchronously
    rdy   = 1'b0;
    valid = 2'b00;
    tick(2'b00, 2'b00);
    valid = 2'b11;
    rdy   = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick(2'b01, 2'b01);
    valid = 2'b00;
    tick(2'b00, 2'b00);
    tick(2'b00, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
